// File: rtl/exact_4x4.sv
// exact_4x4 -- exact 4x4 unsigned multiplier with a registered product.
// Built from four exact 2x2 partial-product blocks and a shifted-add
// accumulation, the same structure as the approximate recursive variants.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset (clears Y)
//   a    in   4-bit unsigned multiplicand
//   b    in   4-bit unsigned multiplier
//   Y    out  8-bit unsigned product a*b, registered (1-cycle latency)

// exact_2x2 -- exact 2-bit x 2-bit unsigned multiplier.
// Ports:
//   a  in   2-bit operand
//   b  in   2-bit operand
//   p  out  4-bit product (3*3 = 9 produced exactly)
module exact_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic lo_lo;
    logic hi_hi;

    always_comb begin
        lo_lo = a[0] & b[0];
        hi_hi = a[1] & b[1];
        p[0]  = lo_lo;
        p[1]  = (a[1] & b[0]) ^ (a[0] & b[1]);
        // Bit 2 is set only for 2*2 and 2*3/3*2; when both LSB products are
        // also set (3*3) the carry moves the weight up to bit 3 instead.
        p[2]  = hi_hi & ~lo_lo;
        p[3]  = hi_hi & lo_lo;
    end
endmodule

module exact_4x4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] Y
);
    logic [3:0] p0;  // aL*bL
    logic [3:0] p1;  // aH*bL
    logic [3:0] p2;  // aL*bH
    logic [3:0] p3;  // aH*bH
    logic [7:0] sum;

    exact_2x2 u_p0 (.a(a[1:0]), .b(b[1:0]), .p(p0));
    exact_2x2 u_p1 (.a(a[3:2]), .b(b[1:0]), .p(p1));
    exact_2x2 u_p2 (.a(a[1:0]), .b(b[3:2]), .p(p2));
    exact_2x2 u_p3 (.a(a[3:2]), .b(b[3:2]), .p(p3));

    always_comb begin
        sum = {4'b0000, p0}
            + {2'b00, p1, 2'b00}
            + {2'b00, p2, 2'b00}
            + {p3, 4'b0000};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y <= '0;
        end else begin
            Y <= sum;
        end
    end
endmodule

// File: tb/tb_exact_4x4.sv
// tb_exact_4x4 -- self-checking bench for exact_4x4.
// Expected products come from plain integer multiplication, pipelined one
// cycle through a queue to match the registered output.
module tb_exact_4x4;
    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] Y;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned sweep_ok = 0;
    logic [7:0]  exp_q[$];

    exact_4x4 dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
        .Y  (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_mul(input int unsigned x, input int unsigned y);
        return 8'(x * y);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: Y=%0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one operand pair, then check it one edge later.
    task automatic apply(input string tag, input int unsigned x, input int unsigned y);
        logic [7:0] e;
        a = 4'(x);
        b = 4'(y);
        exp_q.push_back(ref_mul(x, y));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (Y === e) sweep_ok++;
        check(tag, Y, e);
    endtask

    initial begin
        rst = 1'b1;
        a   = 4'd15;
        b   = 4'd15;

        // Reset held with full-scale operands: output stays 0.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", Y, 8'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release", Y, ref_mul(15, 15));

        // Directed corners.
        apply("corner_3x3", 3, 3);
        apply("corner_12x12", 12, 12);
        apply("corner_15x1", 15, 1);
        apply("zero_a", 0, 13);
        apply("zero_b", 9, 0);
        apply("b2b_first", 7, 9);
        apply("b2b_second", 15, 15);

        // Async reset between edges while Y=225.
        #2;
        rst = 1'b1;
        #1;
        check("async_clear", Y, 8'd0);
        a = 4'd6;
        b = 4'd11;
        @(posedge clk);
        #1;
        check("async_hold", Y, 8'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after_async", Y, ref_mul(6, 11));

        // Exhaustive sweep, one pair per cycle.
        sweep_ok = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            for (int unsigned j = 0; j < 16; j++) begin
                apply("sweep", i, j);
            end
        end
        $display("sweep accuracy = %0.1f%%, error = %0.1f%%",
                 100.0 * real'(sweep_ok) / 256.0,
                 100.0 - 100.0 * real'(sweep_ok) / 256.0);

        // Random back-to-back pairs.
        for (int k = 0; k < 200; k++) begin
            apply("random", $urandom_range(15, 0), $urandom_range(15, 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
